// File: rtl/cmd_reply_packer.sv
// cmd_reply_packer: gathers 16-bit command-reader replies into one 256-word
// command-channel packet (header, timestamp, payload, zero padding) and streams
// it to the RX packet FIFO, while pacing the reader through rx_WR_enabled.
module cmd_reply_packer #(
  parameter int         PAYLOAD_WORDS = 252,
  parameter int         FLUSH_CYCLES  = 64,
  parameter logic [4:0] CHAN          = 5'h1F
) (
  input  logic        txclk,
  input  logic        reset,
  input  logic [31:0] adc_time,
  input  logic [15:0] rx_databus,
  input  logic        rx_WR,
  input  logic        rx_WR_done,
  output logic        rx_WR_enabled,
  output logic [15:0] out_data,
  output logic        out_wr,
  input  logic        out_full,
  output logic        busy,
  output logic        overrun_err
);

  localparam int              IDLE_W    = $clog2(FLUSH_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(FLUSH_CYCLES - 1);
  localparam logic [8:0]      PW        = 9'(PAYLOAD_WORDS);
  localparam logic [8:0]      LAST_WORD = 9'd255;

  localparam logic [2:0] S_FILL    = 3'd0;
  localparam logic [2:0] S_HDR0    = 3'd1;
  localparam logic [2:0] S_HDR1    = 3'd2;
  localparam logic [2:0] S_TS0     = 3'd3;
  localparam logic [2:0] S_TS1     = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_PAD     = 3'd6;

  logic [2:0]        r_state;
  logic [7:0]        r_count;
  logic [7:0]        r_rd;
  logic [8:0]        r_wcnt;
  logic [IDLE_W-1:0] r_idle;
  logic [1:0]        r_reply;
  logic              r_pair;
  logic [31:0]       r_ts;
  logic [15:0]       r_buf [0:PAYLOAD_WORDS-1];
  logic [15:0]       r_out_data;
  logic              r_out_wr;
  logic              r_overrun;

  logic              w_fill;
  logic [8:0]        w_free;
  logic              w_en;
  logic              w_accept;
  logic              w_close;
  logic              w_adv;
  logic [31:0]       w_hdr;
  logic [15:0]       w_word;

  assign w_fill = (r_state == S_FILL);
  assign w_free = PW - {1'b0, r_count};

  // Room for a whole pair, or the second pair of a read reply already under way
  // (two words left is exactly enough for it), so a 4-word reply never splits.
  assign w_en = reset && w_fill &&
                ((w_free >= 9'd4) ||
                 (!rx_WR_done && (r_reply == 2'd2) && (w_free >= 9'd2)));

  // The high word of an open pair is always taken; the bound check is a backstop.
  assign w_accept = w_fill && rx_WR && (w_en || r_pair) && ({1'b0, r_count} < PW);

  // Close only between replies, either when full or after the idle flush delay.
  assign w_close = w_fill && rx_WR_done && !rx_WR &&
                   ((w_free < 9'd4) || ((r_count != 8'd0) && (r_idle == IDLE_LAST)));

  assign w_adv = !w_fill && !out_full;
  assign w_hdr = {3'b000, 2'b11, 6'b000000, CHAN, 7'b0000000, r_count, 1'b0};

  // Word presented to the FIFO for the current drain state.
  always_comb begin
    w_word = 16'h0000;
    case (r_state)
      S_HDR0:    w_word = w_hdr[15:0];
      S_HDR1:    w_word = w_hdr[31:16];
      S_TS0:     w_word = r_ts[15:0];
      S_TS1:     w_word = r_ts[31:16];
      S_PAYLOAD: w_word = r_buf[r_rd];
      default:   w_word = 16'h0000;
    endcase
  end

  // Payload storage and timestamp capture; contents are only meaningful up to r_count.
  always_ff @(posedge txclk) begin
    if (w_accept) begin
      r_buf[r_count] <= rx_databus;
      if (r_count == 8'd0) r_ts <= adc_time;
    end
  end

  // Packet state machine, flow-control bookkeeping and FIFO write port.
  always_ff @(posedge txclk) begin
    if (!reset) begin
      r_state    <= S_FILL;
      r_count    <= 8'd0;
      r_rd       <= 8'd0;
      r_wcnt     <= 9'd0;
      r_idle     <= '0;
      r_reply    <= 2'd0;
      r_pair     <= 1'b0;
      r_out_data <= 16'h0000;
      r_out_wr   <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_out_wr <= w_adv;
      if (w_adv) r_out_data <= w_word;
      if (rx_WR && !w_accept) r_overrun <= 1'b1;

      if (rx_WR_done)                       r_reply <= 2'd0;
      else if (w_accept && r_reply != 2'd3) r_reply <= r_reply + 2'd1;

      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_count <= r_count + 8'd1;
            r_pair  <= ~r_pair;
            r_idle  <= '0;
          end else if (rx_WR) begin
            r_idle <= '0;
          end else if (w_close) begin
            r_state <= S_HDR0;
            r_idle  <= '0;
            r_pair  <= 1'b0;
            r_wcnt  <= 9'd0;
            r_rd    <= 8'd0;
          end else if ((r_count != 8'd0) && rx_WR_done) begin
            r_idle <= r_idle + 1'b1;
          end
        end
        S_HDR0, S_HDR1, S_TS0, S_TS1: begin
          if (!out_full) begin
            r_state <= r_state + 3'd1;
            r_wcnt  <= r_wcnt + 9'd1;
          end
        end
        S_PAYLOAD: begin
          if (!out_full) begin
            r_wcnt <= r_wcnt + 9'd1;
            r_rd   <= r_rd + 8'd1;
            if (r_rd == r_count - 8'd1) begin
              if (r_wcnt == LAST_WORD) begin
                r_state <= S_FILL;
                r_count <= 8'd0;
              end else begin
                r_state <= S_PAD;
              end
            end
          end
        end
        S_PAD: begin
          if (!out_full) begin
            r_wcnt <= r_wcnt + 9'd1;
            if (r_wcnt == LAST_WORD) begin
              r_state <= S_FILL;
              r_count <= 8'd0;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign rx_WR_enabled = w_en;
  assign busy          = reset && !w_fill;
  assign out_data      = r_out_data;
  assign out_wr        = r_out_wr;
  assign overrun_err   = r_overrun;

endmodule

// File: tb/tb_cmd_reply_packer.sv
// Directed testbench for cmd_reply_packer: each scenario task drives its own
// stimulus and compares the captured packet stream against hand-built values.
module tb_cmd_reply_packer;

  logic        txclk;
  logic        reset;
  logic [31:0] adc_time;
  logic [15:0] rx_databus;
  logic        rx_WR;
  logic        rx_WR_done;
  logic        rx_WR_enabled;
  logic [15:0] out_data;
  logic        out_wr;
  logic        out_full;
  logic        busy;
  logic        overrun_err;

  int          n_cmp;
  int          n_err;
  logic [15:0] cap [$];
  logic [15:0] pay [0:251];
  logic [15:0] exp_w [0:255];

  cmd_reply_packer dut (
    .txclk         (txclk),
    .reset         (reset),
    .adc_time      (adc_time),
    .rx_databus    (rx_databus),
    .rx_WR         (rx_WR),
    .rx_WR_done    (rx_WR_done),
    .rx_WR_enabled (rx_WR_enabled),
    .out_data      (out_data),
    .out_wr        (out_wr),
    .out_full      (out_full),
    .busy          (busy),
    .overrun_err   (overrun_err)
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  always @(posedge txclk) adc_time <= adc_time + 32'h0001_0003;

  task automatic tick();
    @(posedge txclk);
    #1;
  endtask

  task automatic build_exp(input int cnt, input logic [31:0] ts, input logic [15:0] hdr_lo);
    exp_w[0] = hdr_lo;
    exp_w[1] = 16'h181F;
    exp_w[2] = ts[15:0];
    exp_w[3] = ts[31:16];
    for (int i = 0; i < 252; i++) exp_w[4+i] = (i < cnt) ? pay[i] : 16'h0000;
  endtask

  // Gathers drain words; optionally toggles out_full, injects a stray rx_WR,
  // or asserts reset once a given number of words has been seen.
  task automatic collect(input int limit, input bit toggle, input int pulse_at, input int reset_at);
    cap.delete();
    for (int n = 0; n < limit && cap.size() < 256; n++) begin
      tick();
      rx_WR = 1'b0;
      if (out_wr) cap.push_back(out_data);
      if (out_wr && cap.size() == reset_at) begin
        reset    = 1'b0;
        out_full = 1'b0;
        return;
      end
      if (out_wr && cap.size() == pulse_at) begin
        rx_databus = 16'hDEAD;
        rx_WR      = 1'b1;
      end
      out_full = toggle ? !out_full : 1'b0;
    end
    out_full = 1'b0;
    rx_WR    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++; if (rx_WR_enabled !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %b want 0", rx_WR_enabled); end
    n_cmp++; if (out_wr !== 1'b0) begin n_err++; $display("FAIL reset_out_wr: got %b want 0", out_wr); end
    n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun_err); end
    reset = 1'b1;
    tick();
    n_cmp++; if (rx_WR_enabled !== 1'b1) begin n_err++; $display("FAIL release_enable: got %b want 1", rx_WR_enabled); end
  endtask

  task automatic test_single(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] ts;
    int n;
    n_cmp++; if (rx_WR_enabled !== 1'b1) begin n_err++; $display("FAIL single_enable_idle: got %b want 1", rx_WR_enabled); end
    ts = adc_time;
    rx_databus = a; rx_WR = 1'b1;
    tick();
    rx_databus = b;
    tick();
    rx_WR = 1'b0;
    n = 0;
    while (!busy && n < 300) begin tick(); n++; end
    n_cmp++; if (n !== 64) begin n_err++; $display("FAIL single_flush_wait: got %0d want 64", n); end
    pay[0] = a; pay[1] = b;
    build_exp(2, ts, 16'h0004);
    collect(600, 1'b0, -1, -1);
    n_cmp++; if (cap.size() !== 256) begin n_err++; $display("FAIL single_len: got %0d want 256", cap.size()); end
    for (int i = 0; i < cap.size() && i < 256; i++) begin
      n_cmp++; if (cap[i] !== exp_w[i]) begin n_err++; $display("FAIL single_word[%0d]: got %h want %h", i, cap[i], exp_w[i]); end
    end
    n_cmp++; if (rx_WR_enabled !== 1'b1) begin n_err++; $display("FAIL single_enable_after: got %b want 1", rx_WR_enabled); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ts;
    ts = 32'h0;
    rx_WR_done = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if (i == 248) begin
        n_cmp++; if (rx_WR_enabled !== 1'b1) begin n_err++; $display("FAIL b2b_enable_248: got %b want 1", rx_WR_enabled); end
      end
      if (i == 0) ts = adc_time;
      pay[i] = 16'(i * 3 + 256);
      rx_databus = pay[i]; rx_WR = 1'b1;
      tick();
    end
    rx_WR = 1'b0;
    n_cmp++; if (rx_WR_enabled !== 1'b0) begin n_err++; $display("FAIL b2b_enable_250: got %b want 0", rx_WR_enabled); end
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_close: got %b want 1", busy); end
    build_exp(250, ts, 16'h01F4);
    collect(600, 1'b0, -1, -1);
    n_cmp++; if (cap.size() !== 256) begin n_err++; $display("FAIL b2b_len: got %0d want 256", cap.size()); end
    for (int i = 0; i < cap.size() && i < 256; i++) begin
      n_cmp++; if (cap[i] !== exp_w[i]) begin n_err++; $display("FAIL b2b_word[%0d]: got %h want %h", i, cap[i], exp_w[i]); end
    end
    n_cmp++; if (rx_WR_enabled !== 1'b1) begin n_err++; $display("FAIL b2b_enable_after: got %b want 1", rx_WR_enabled); end
  endtask

  task automatic test_read_reply();
    logic [31:0] ts;
    logic [3:0]  en_exp;
    int          busy_seen;
    ts = 32'h0;
    en_exp = 4'b0101;
    rx_WR_done = 1'b1;
    for (int i = 0; i < 248; i++) begin
      if (i == 0) ts = adc_time;
      pay[i] = 16'h7000 ^ 16'(i);
      rx_databus = pay[i]; rx_WR = 1'b1;
      tick();
    end
    rx_WR_done = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_cmp++; if (rx_WR_enabled !== en_exp[j]) begin n_err++; $display("FAIL rr_enable_%0d: got %b want %b", j, rx_WR_enabled, en_exp[j]); end
      pay[248+j] = 16'hF000 + 16'(j);
      rx_databus = pay[248+j]; rx_WR = 1'b1;
      tick();
    end
    rx_WR = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy) busy_seen++;
    end
    n_cmp++; if (busy_seen !== 0) begin n_err++; $display("FAIL rr_hold_open: got %0d busy cycles want 0", busy_seen); end
    rx_WR_done = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rr_close: got %b want 1", busy); end
    build_exp(252, ts, 16'h01F8);
    collect(600, 1'b0, -1, -1);
    n_cmp++; if (cap.size() !== 256) begin n_err++; $display("FAIL rr_len: got %0d want 256", cap.size()); end
    for (int i = 0; i < cap.size() && i < 256; i++) begin
      n_cmp++; if (cap[i] !== exp_w[i]) begin n_err++; $display("FAIL rr_word[%0d]: got %h want %h", i, cap[i], exp_w[i]); end
    end
    n_cmp++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL rr_no_overrun: got %b want 0", overrun_err); end
  endtask

  task automatic test_full_toggle();
    logic [31:0] ts;
    int n;
    int extra;
    ts = adc_time;
    rx_databus = 16'h5555; rx_WR = 1'b1;
    tick();
    rx_databus = 16'hAAAA;
    tick();
    rx_WR = 1'b0;
    n = 0;
    while (!busy && n < 300) begin tick(); n++; end
    pay[0] = 16'h5555; pay[1] = 16'hAAAA;
    build_exp(2, ts, 16'h0004);
    collect(1200, 1'b1, -1, -1);
    n_cmp++; if (cap.size() !== 256) begin n_err++; $display("FAIL toggle_len: got %0d want 256", cap.size()); end
    for (int i = 0; i < cap.size() && i < 256; i++) begin
      n_cmp++; if (cap[i] !== exp_w[i]) begin n_err++; $display("FAIL toggle_word[%0d]: got %h want %h", i, cap[i], exp_w[i]); end
    end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_wr) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL toggle_extra_wr: got %0d want 0", extra); end
  endtask

  task automatic test_overrun_drain();
    logic [31:0] ts;
    int n;
    n_cmp++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL ovr_initial: got %b want 0", overrun_err); end
    ts = adc_time;
    rx_databus = 16'h0F0F; rx_WR = 1'b1;
    tick();
    rx_databus = 16'hF0F0;
    tick();
    rx_WR = 1'b0;
    n = 0;
    while (!busy && n < 300) begin tick(); n++; end
    pay[0] = 16'h0F0F; pay[1] = 16'hF0F0;
    build_exp(2, ts, 16'h0004);
    collect(600, 1'b0, 50, -1);
    n_cmp++; if (cap.size() !== 256) begin n_err++; $display("FAIL ovr_len: got %0d want 256", cap.size()); end
    for (int i = 0; i < cap.size() && i < 256; i++) begin
      n_cmp++; if (cap[i] !== exp_w[i]) begin n_err++; $display("FAIL ovr_word[%0d]: got %h want %h", i, cap[i], exp_w[i]); end
    end
    n_cmp++; if (overrun_err !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun_err); end
    for (int k = 0; k < 5; k++) tick();
    n_cmp++; if (overrun_err !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", overrun_err); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL ovr_cleared: got %b want 0", overrun_err); end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    int extra;
    rx_databus = 16'h1111; rx_WR = 1'b1;
    tick();
    rx_databus = 16'h2222;
    tick();
    rx_WR = 1'b0;
    n = 0;
    while (!busy && n < 300) begin tick(); n++; end
    collect(600, 1'b0, -1, 100);
    n_cmp++; if (cap.size() !== 100) begin n_err++; $display("FAIL rst_drain_reached: got %0d want 100", cap.size()); end
    tick();
    n_cmp++; if (out_wr !== 1'b0) begin n_err++; $display("FAIL rst_drain_out_wr: got %b want 0", out_wr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_drain_busy: got %b want 0", busy); end
    tick();
    reset = 1'b1;
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      if (out_wr) extra++;
      tick();
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL rst_drain_no_more: got %0d want 0", extra); end
    test_single(16'hBEEF, 16'h0042);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    adc_time   = 32'h89AB_0000;
    reset      = 1'b0;
    rx_databus = 16'h0000;
    rx_WR      = 1'b0;
    rx_WR_done = 1'b1;
    out_full   = 1'b0;

    test_reset();
    test_single(16'h1234, 16'h0102);
    test_back_to_back();
    test_read_reply();
    test_full_toggle();
    test_overrun_drain();
    test_reset_mid_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
